// File: rtl/data_memory_sync.sv
// Synchronous data memory: registered read (1-cycle latency, dataValid strobe), byte-lane writes, write-first forwarding.
// No backpressure; requests seen while ready=0 (post-reset zero-fill sweep) are dropped, never queued.
module data_memory_sync #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    memReadSignal,
    input  logic                    memWriteSignal,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writeData,
    output logic [DATA_WIDTH-1:0]   dataOut,
    output logic                    dataValid,
    output logic                    ready,
    output logic                    addrError
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t                 state, stateNext;
    logic [IDX_W-1:0]       clearAddr, clearAddrNext;
    logic                   clearWrite;
    logic                   inRange, acceptRead, acceptWrite;
    logic [IDX_W-1:0]       wordIdx;
    logic [DATA_WIDTH-1:0]  oldWord, mergedWord;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    assign inRange     = {1'b0, address} < DEPTH_LIM;
    assign wordIdx     = address[IDX_W-1:0];
    assign acceptRead  = ready & memReadSignal;
    assign acceptWrite = ready & memWriteSignal;
    assign oldWord     = mem[wordIdx];

    // Write-first: a read to the word being written returns the merged result.
    always_comb begin
        mergedWord = oldWord;
        for (int i = 0; i < LANES; i++) begin
            if (acceptWrite && byteEnable[i]) begin
                mergedWord[8*i +: 8] = writeData[8*i +: 8];
            end
        end
    end

    always_comb begin
        stateNext     = state;
        clearAddrNext = clearAddr;
        clearWrite    = 1'b0;
        case (state)
            CLEAR: begin
                clearWrite    = 1'b1;
                clearAddrNext = clearAddr + 1'b1;
                if (clearAddr == LAST_IDX) begin
                    stateNext     = RUN;
                    clearAddrNext = '0;
                end
            end
            RUN:     stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state     <= RESET_STATE;
            clearAddr <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            addrError <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state     <= stateNext;
            clearAddr <= clearAddrNext;
            ready     <= (stateNext == RUN);
            dataValid <= acceptRead;
            addrError <= (acceptRead | acceptWrite) & ~inRange;
            if (acceptRead) begin
                dataOut <= inRange ? mergedWord : '0;
            end
        end
    end

    // Array has no reset; resetN only blocks writes while it is asserted.
    always_ff @(posedge clock) begin
        if (resetN) begin
            if (clearWrite) begin
                mem[clearAddr] <= '0;
            end else if (acceptWrite && inRange) begin
                for (int i = 0; i < LANES; i++) begin
                    if (byteEnable[i]) begin
                        mem[wordIdx][8*i +: 8] <= writeData[8*i +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench: 16-bit/16-word instance with clear sweep, 8-bit/200-word instance without sweep.
module tb_data_memory_sync;
    logic        clock;
    logic        resetNA, memReadA, memWriteA, validA, readyA, errA;
    logic [1:0]  beA;
    logic [7:0]  addrA;
    logic [15:0] wdA, doutA;
    logic        resetNB, memReadB, memWriteB, validB, readyB, errB;
    logic [0:0]  beB;
    logic [7:0]  addrB, wdB, doutB;

    int checks   = 0;
    int failures = 0;
    int n;
    int bad;

    data_memory_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(16), .CLEAR_ON_RESET(1)) dutA (
        .clock(clock), .resetN(resetNA), .memReadSignal(memReadA), .memWriteSignal(memWriteA),
        .byteEnable(beA), .address(addrA), .writeData(wdA), .dataOut(doutA),
        .dataValid(validA), .ready(readyA), .addrError(errA)
    );

    data_memory_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .CLEAR_ON_RESET(0)) dutB (
        .clock(clock), .resetN(resetNB), .memReadSignal(memReadB), .memWriteSignal(memWriteB),
        .byteEnable(beB), .address(addrB), .writeData(wdB), .dataOut(doutB),
        .dataValid(validB), .ready(readyB), .addrError(errB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic wrA(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        memWriteA = 1'b1; addrA = a; wdA = d; beA = be;
        tick;
        memWriteA = 1'b0; beA = 2'b00;
    endtask

    task automatic rdA(input logic [7:0] a);
        memReadA = 1'b1; addrA = a;
        tick;
        memReadA = 1'b0;
    endtask

    task automatic wrB(input logic [7:0] a, input logic [7:0] d);
        memWriteB = 1'b1; addrB = a; wdB = d; beB = 1'b1;
        tick;
        memWriteB = 1'b0; beB = 1'b0;
    endtask

    task automatic rdB(input logic [7:0] a);
        memReadB = 1'b1; addrB = a;
        tick;
        memReadB = 1'b0;
    endtask

    // Counts samples with ready=0, starting at the current one; bounded.
    task automatic waitReadyA(output int cnt);
        cnt = 0;
        while (!readyA && cnt < 40) begin
            cnt++;
            tick;
        end
    endtask

    initial begin
        resetNA = 1'b0; memReadA = 1'b0; memWriteA = 1'b0; beA = '0; addrA = '0; wdA = '0;
        resetNB = 1'b0; memReadB = 1'b0; memWriteB = 1'b0; beB = '0; addrB = '0; wdB = '0;
        tick; tick;

        check("rst_readyA", readyA, 0);
        check("rst_validA", validA, 0);
        check("rst_doutA",  doutA,  0);
        check("rst_errA",   errA,   0);
        check("rst_readyB", readyB, 0);
        check("rst_doutB",  doutB,  0);

        // T1: power-up sweep, garbage, pulsed reset, full re-sweep
        resetNA = 1'b1;
        waitReadyA(n);
        check("t1_sweep0_len", n, 16);
        for (int i = 0; i < 16; i++) wrA(8'(i), 16'hDEAD, 2'b11);
        resetNA = 1'b0;
        tick;
        check("t1_rst_ready", readyA, 0);
        resetNA = 1'b1;
        waitReadyA(n);
        check("t1_sweep1_len", n, 16);
        for (int i = 0; i < 16; i++) begin
            rdA(8'(i));
            check("t1_valid", validA, 1);
            check("t1_zero",  doutA,  0);
        end

        // T2: write then read, then idle holds data
        wrA(8'h03, 16'h00A5, 2'b11);
        rdA(8'h03);
        check("t2_valid", validA, 1);
        check("t2_data",  doutA,  16'h00A5);
        tick;
        check("t2_idle_valid", validA, 0);
        check("t2_idle_hold",  doutA,  16'h00A5);

        // T3: byte-lane merge
        wrA(8'h05, 16'h1234, 2'b11);
        wrA(8'h05, 16'hABCD, 2'b01);
        rdA(8'h05);
        check("t3_merge", doutA, 16'h12CD);
        wrA(8'h03, 16'hFFFF, 2'b00);
        check("be0_err", errA, 0);
        rdA(8'h03);
        check("be0_nochg", doutA, 16'h00A5);

        // T4: read-during-write forwarding, full and partial lanes
        wrA(8'h07, 16'h0011, 2'b11);
        memReadA = 1'b1; memWriteA = 1'b1; addrA = 8'h07; wdA = 16'h0099; beA = 2'b11;
        tick;
        check("t4_fwd_full", doutA, 16'h0099);
        wdA = 16'hFF00; beA = 2'b10;
        tick;
        memReadA = 1'b0; memWriteA = 1'b0; beA = 2'b00;
        check("t4_fwd_part", doutA, 16'hFF99);
        wrA(8'h08, 16'h4242, 2'b11);
        rdA(8'h07);
        check("t4_rd7", doutA, 16'hFF99);
        rdA(8'h08);
        check("t4_rd8", doutA, 16'h4242);
        check("t4_err", errA, 0);

        // Out of range on the 16-word instance: 0x13 must not alias word 3
        wrA(8'h13, 16'hBEEF, 2'b11);
        check("oorA_wr_err",   errA,   1);
        check("oorA_wr_valid", validA, 0);
        tick;
        check("oorA_err_pulse", errA, 0);
        rdA(8'h03);
        check("oorA_noalias", doutA, 16'h00A5);
        rdA(8'h10);
        check("oorA_rd_valid", validA, 1);
        check("oorA_rd_data",  doutA,  0);
        check("oorA_rd_err",   errA,   1);
        rdA(8'h0F);
        check("edgeA_rd15_err", errA, 0);

        // T6: reset mid-sweep at clearAddr=9, requests during sweep dropped
        for (int i = 0; i < 16; i++) wrA(8'(i), 16'h5A5A, 2'b11);
        resetNA = 1'b0;
        tick;
        resetNA = 1'b1;
        repeat (9) tick;
        check("t6_mid_ready", readyA, 0);
        resetNA = 1'b0;
        tick;
        resetNA = 1'b1;
        memReadA = 1'b1; memWriteA = 1'b1; addrA = 8'h00; wdA = 16'h7777; beA = 2'b11;
        n = 0; bad = 0;
        while (!readyA && n < 40) begin
            n++;
            tick;
            if (validA !== 1'b0 || errA !== 1'b0) bad++;
        end
        memReadA = 1'b0; memWriteA = 1'b0; beA = 2'b00;
        check("t6_sweep_len", n, 16);
        check("t6_no_strobes", bad, 0);
        for (int i = 0; i < 16; i++) begin
            rdA(8'(i));
            check("t6_zero", doutA, 0);
        end

        // T5: 200-word instance without sweep
        resetNB = 1'b1;
        n = 0;
        while (!readyB && n < 40) begin
            n++;
            tick;
        end
        check("t5_readyB_delay", n, 1);
        wrB(8'h70, 8'h55);
        wrB(8'hC7, 8'h3C);
        wrB(8'hF0, 8'h66);
        check("t5_wr_err", errB, 1);
        tick;
        check("t5_err_pulse", errB, 0);
        rdB(8'h70);
        check("t5_rd70", doutB, 8'h55);
        rdB(8'hF0);
        check("t5_oor_valid", validB, 1);
        check("t5_oor_data",  doutB,  0);
        check("t5_oor_err",   errB,   1);
        rdB(8'hC7);
        check("t5_rd199",     doutB, 8'h3C);
        check("t5_rd199_err", errB,  0);
        rdB(8'hC8);
        check("t5_rd200_err", errB, 1);
        rdB(8'h70);
        check("t5_rd70_again", doutB, 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
